panda_decoder_stage: RTL and testbench
======================================

Name: panda_decoder_stage

Overview:
Registered, parametrised RV32 decode stage between fetch and execute.
- Accepts {instr, pc} over a valid/ready handshake.
- Decodes RV32I, with optional RV32E and RV32M and with FENCE/ECALL/EBREAK recognition.
- Presents one decoded packet per instruction through a 2-entry skid buffer.
- Its ready output is a pure register, so there is no combinational path from ready_i to instr_ready_o.

Parameters:
RV32E, 0, 1 = only x0..x15 legal; any rs1/rs2/rd field with bit 4 set makes the instruction illegal.
RV32M, 0, 1 = decode OP funct7=0000001 as multiply/divide; 0 = those encodings are illegal.
SYSTEM_EN, 1, 1 = decode FENCE, ECALL and EBREAK; 0 = MISC_MEM and SYSTEM opcodes are illegal.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  drop everything held and any same-cycle input
instr_valid_i  in  1  fetch has an instruction
instr_ready_o  out  1  stage can accept
instr_i  in  32  instruction word
pc_i  in  32  instruction address
dec_valid_o  out  1  dec_o is valid
dec_ready_i  in  1  execute accepts dec_o
dec_o  out  $bits(decoded_instr_t)  decoded packet

Behaviour:
- Reset (rst_i high at a clock edge):
  - dec_valid_o=0, dec_o='0, skid entry empty.
  - instr_ready_o=1 from the first cycle after reset.
  - Reset mid-transfer discards both entries with no output.
- Transfer rules:
  - Input transfer: instr_valid_i & instr_ready_o.
  - Output transfer: dec_valid_o & dec_ready_i.
- Latency: an instruction accepted at edge N appears on dec_o after edge N, i.e. 1 cycle, when the main register is empty or draining.
- Storage: main register M (drives dec_o) and skid register S.
  - instr_ready_o = !S.valid, registered.
- Next-state rules, evaluated with flush_i=0:
  - Input and M empty or M draining: M <= decode(input).
  - Input, M full, not draining: S <= decode(input); instr_ready_o drops next cycle.
  - M draining and S full: M <= S, S cleared.
  - Input is never accepted while S is full.
- Ordering is strictly FIFO; no instruction is duplicated or lost.
- flush_i high:
  - M.valid and S.valid are cleared; a same-cycle input transfer is discarded.
  - A same-cycle output transfer still counts as consumed by execute.
  - instr_ready_o=1 next cycle. flush_i beats all other events; rst_i beats flush_i.
- Decode is combinational on instr_i before the register:
  - Immediates per I/S/B/U/J format, sign-extended.
  - Default: alu ADD, op_a RS1, op_b RS2, rd_data ALU, all enables 0.
- Legal opcode set: LOAD, STORE, OP, OP_IMM, LUI, AUIPC, BRANCH, JAL, JALR, plus MISC_MEM and SYSTEM when SYSTEM_EN=1.
- Illegal instruction, any of:
  - Unknown opcode.
  - instr_i[1:0] != 2'b11.
  - Bad funct3/funct7.
  - LOAD funct3 in {3,6,7}; STORE funct3 >= 3.
  - SYSTEM other than exactly 0x00000073 / 0x00100073.
  - RV32E register violation.
- On illegal: illegal=1 and rd_we, lsu_load, lsu_store, branch, jump, md_en are forced 0. The packet is still emitted, carrying its pc, for the trap logic.
- RV32M=1: OP with funct7=0000001 sets md_en=1 and md_operator=funct3 (MUL..REMU); rd_data_sel=RD_DATA_MD.
- FENCE: fence=1, no register write. ECALL/EBREAK: ecall/ebreak=1, no register write.
- rd_we is forced 0 when rd=0.

Decomposition:
- panda_pkg gains:
  - md_operator_e (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
  - RD_DATA_MD in rd_data_sel_e.
  - OPCODE_MISC_MEM and OPCODE_SYSTEM.
  - decoded_instr_t packed struct: rs1, rs2, rd, rd_we, op_a_sel, op_b_sel, rd_data_sel, alu_operator, md_en, md_operator, lsu_load, lsu_store, lsu_width, lsu_unsigned, branch, jump, fence, ecall, ebreak, imm, pc, illegal.
- Sub-module panda_decoder_core: purely combinational, parameter-passed, produces decoded_instr_t. The stage module holds only the handshake and the M/S registers.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) valid with dec_ready_i=1 -> next cycle dec_valid_o=1, rd=3, rd_we=1, alu ADD, illegal=0.
- dec_ready_i=0, send 3 back-to-back instrs -> first two accepted, instr_ready_o=0 from cycle 3. Raise ready -> outputs in exact order, no duplicates.
- S full and flush_i pulse together with instr_valid_i -> next cycle dec_valid_o=0, instr_ready_o=1, the flushed instrs never appear.
- MUL x5,x6,x7 (0x027302B3): RV32M=0 -> illegal=1, rd_we=0. RV32M=1 -> md_en=1, md_operator=MUL, rd_we=1.
- RV32E=1, ADDI x16,x0,1 (0x00100813) -> illegal=1. Same instr with RV32E=0 -> legal, imm=1.
- 0x00000073 -> ecall=1; 0x00200073 -> illegal=1; 0xFFFFFFFF -> illegal=1; LUI x0 -> rd_we=0.

Source files
------------

// File: rtl/panda_pkg.sv
// Shared types for the panda RV32 front end: opcodes, operand/result selectors
// and the decoded instruction packet handed from decode to execute.
package panda_pkg;

   typedef enum logic [6:0] {
      OPCODE_LOAD     = 7'h03,
      OPCODE_MISC_MEM = 7'h0f,
      OPCODE_OP_IMM   = 7'h13,
      OPCODE_AUIPC    = 7'h17,
      OPCODE_STORE    = 7'h23,
      OPCODE_OP       = 7'h33,
      OPCODE_LUI      = 7'h37,
      OPCODE_BRANCH   = 7'h63,
      OPCODE_JALR     = 7'h67,
      OPCODE_JAL      = 7'h6f,
      OPCODE_SYSTEM   = 7'h73
   } opcode_e;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
   } alu_op_e;

   typedef enum logic [1:0] {
      OP_A_RS1,
      OP_A_PC,
      OP_A_ZERO
   } op_a_sel_e;

   typedef enum logic {
      OP_B_RS2,
      OP_B_IMM
   } op_b_sel_e;

   typedef enum logic [1:0] {
      RD_DATA_ALU,
      RD_DATA_LSU,
      RD_DATA_PC4,
      RD_DATA_MD
   } rd_data_sel_e;

   // Encoding follows funct3 so the decoder can cast it directly.
   typedef enum logic [2:0] {
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
   } md_operator_e;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   typedef struct packed {
      logic [4:0]   rs1;
      logic [4:0]   rs2;
      logic [4:0]   rd;
      logic         rd_we;
      op_a_sel_e    op_a_sel;
      op_b_sel_e    op_b_sel;
      rd_data_sel_e rd_data_sel;
      alu_op_e      alu_operator;
      logic         md_en;
      md_operator_e md_operator;
      logic         lsu_load;
      logic         lsu_store;
      logic [1:0]   lsu_width;
      logic         lsu_unsigned;
      logic         branch;
      logic         jump;
      logic         fence;
      logic         ecall;
      logic         ebreak;
      logic [31:0]  imm;
      logic [31:0]  pc;
      logic         illegal;
   } decoded_instr_t;

   localparam int DEC_W = $bits(decoded_instr_t);

   // Register/immediate arithmetic op; alt selects SUB/SRA.
   function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      case (funct3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic alu_op_e branch_op_from_funct3(input logic [2:0] funct3);
      alu_op_e op;
      case (funct3)
         3'd0:    op = ALU_EQ;
         3'd1:    op = ALU_NE;
         3'd4:    op = ALU_LT;
         3'd5:    op = ALU_GE;
         3'd6:    op = ALU_LTU;
         default: op = ALU_GEU;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/panda_decoder_core.sv
// Purely combinational RV32I(+E/M) instruction decoder producing one
// decoded_instr_t per instruction word, with illegal-instruction detection.
module panda_decoder_core
   import panda_pkg::*;
#(
   parameter bit RV32E     = 1'b0,
   parameter bit RV32M     = 1'b0,
   parameter bit SYSTEM_EN = 1'b1
) (
   input  logic [31:0]      instr_i,
   input  logic [31:0]      pc_i,
   output logic [DEC_W-1:0] dec_o
);

   logic [2:0]     funct3;
   logic [6:0]     funct7;
   logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
   decoded_instr_t raw;
   decoded_instr_t fin;
   logic           legal_op;
   logic           use_rs1, use_rs2, use_rd;
   logic [4:0]     reg_field [3];
   logic [2:0]     reg_used;
   logic [2:0]     reg_bad;
   logic           rv32e_violation;
   logic           illegal;

   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_u = {instr_i[31:12], 12'h000};
   assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

   always_comb begin
      raw              = '0;
      raw.rs1          = instr_i[19:15];
      raw.rs2          = instr_i[24:20];
      raw.rd           = instr_i[11:7];
      raw.pc           = pc_i;
      raw.alu_operator = ALU_ADD;
      raw.op_a_sel     = OP_A_RS1;
      raw.op_b_sel     = OP_B_RS2;
      raw.rd_data_sel  = RD_DATA_ALU;
      raw.md_operator  = MD_MUL;
      legal_op         = 1'b0;
      use_rs1          = 1'b0;
      use_rs2          = 1'b0;
      use_rd           = 1'b0;

      case (instr_i[6:0])
         OPCODE_LUI: begin
            legal_op      = 1'b1;
            use_rd        = 1'b1;
            raw.rd_we     = 1'b1;
            raw.op_a_sel  = OP_A_ZERO;
            raw.op_b_sel  = OP_B_IMM;
            raw.imm       = imm_u;
         end
         OPCODE_AUIPC: begin
            legal_op      = 1'b1;
            use_rd        = 1'b1;
            raw.rd_we     = 1'b1;
            raw.op_a_sel  = OP_A_PC;
            raw.op_b_sel  = OP_B_IMM;
            raw.imm       = imm_u;
         end
         OPCODE_JAL: begin
            legal_op        = 1'b1;
            use_rd          = 1'b1;
            raw.rd_we       = 1'b1;
            raw.jump        = 1'b1;
            raw.op_a_sel    = OP_A_PC;
            raw.op_b_sel    = OP_B_IMM;
            raw.rd_data_sel = RD_DATA_PC4;
            raw.imm         = imm_j;
         end
         OPCODE_JALR: begin
            legal_op        = (funct3 == 3'd0);
            use_rs1         = 1'b1;
            use_rd          = 1'b1;
            raw.rd_we       = 1'b1;
            raw.jump        = 1'b1;
            raw.op_b_sel    = OP_B_IMM;
            raw.rd_data_sel = RD_DATA_PC4;
            raw.imm         = imm_i;
         end
         OPCODE_BRANCH: begin
            legal_op         = (funct3 != 3'd2) && (funct3 != 3'd3);
            use_rs1          = 1'b1;
            use_rs2          = 1'b1;
            raw.branch       = 1'b1;
            raw.alu_operator = branch_op_from_funct3(funct3);
            raw.imm          = imm_b;
         end
         OPCODE_LOAD: begin
            legal_op         = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            use_rs1          = 1'b1;
            use_rd           = 1'b1;
            raw.rd_we        = 1'b1;
            raw.lsu_load     = 1'b1;
            raw.lsu_width    = funct3[1:0];
            raw.lsu_unsigned = funct3[2];
            raw.op_b_sel     = OP_B_IMM;
            raw.rd_data_sel  = RD_DATA_LSU;
            raw.imm          = imm_i;
         end
         OPCODE_STORE: begin
            legal_op      = (funct3 < 3'd3);
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
            raw.lsu_store = 1'b1;
            raw.lsu_width = funct3[1:0];
            raw.op_b_sel  = OP_B_IMM;
            raw.imm       = imm_s;
         end
         OPCODE_OP_IMM: begin
            // Only shifts carry a funct7; elsewhere those bits are immediate.
            unique case (funct3)
               3'd1:    legal_op = (funct7 == 7'h00);
               3'd5:    legal_op = (funct7 == 7'h00) || (funct7 == 7'h20);
               default: legal_op = 1'b1;
            endcase
            use_rs1          = 1'b1;
            use_rd           = 1'b1;
            raw.rd_we        = 1'b1;
            raw.op_b_sel     = OP_B_IMM;
            raw.alu_operator = alu_op_from_funct3(funct3, (funct3 == 3'd5) && funct7[5]);
            raw.imm          = imm_i;
         end
         OPCODE_OP: begin
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            use_rd    = 1'b1;
            raw.rd_we = 1'b1;
            if (funct7 == 7'h00) begin
               legal_op         = 1'b1;
               raw.alu_operator = alu_op_from_funct3(funct3, 1'b0);
            end else if (funct7 == 7'h20) begin
               legal_op         = (funct3 == 3'd0) || (funct3 == 3'd5);
               raw.alu_operator = alu_op_from_funct3(funct3, 1'b1);
            end else if (RV32M && funct7 == 7'h01) begin
               legal_op        = 1'b1;
               raw.md_en       = 1'b1;
               raw.md_operator = md_operator_e'(funct3);
               raw.rd_data_sel = RD_DATA_MD;
            end
         end
         OPCODE_MISC_MEM: begin
            if (SYSTEM_EN && funct3 == 3'd0) begin
               legal_op  = 1'b1;
               raw.fence = 1'b1;
            end
         end
         OPCODE_SYSTEM: begin
            if (SYSTEM_EN) begin
               raw.ecall  = (instr_i == INSTR_ECALL);
               raw.ebreak = (instr_i == INSTR_EBREAK);
               legal_op   = raw.ecall || raw.ebreak;
            end
         end
         default: legal_op = 1'b0;
      endcase
   end

   // Only register fields the format actually uses are checked against x15.
   assign reg_field[0] = instr_i[19:15];
   assign reg_field[1] = instr_i[24:20];
   assign reg_field[2] = instr_i[11:7];
   assign reg_used     = {use_rd, use_rs2, use_rs1};

   for (genvar gi = 0; gi < 3; gi++) begin : g_reg_chk
      assign reg_bad[gi] = reg_used[gi] & reg_field[gi][4];
   end

   assign rv32e_violation = RV32E && (|reg_bad);
   assign illegal         = !legal_op || (instr_i[1:0] != 2'b11) || rv32e_violation;

   always_comb begin
      fin         = raw;
      fin.illegal = illegal;
      if (illegal) begin
         fin.rd_we     = 1'b0;
         fin.lsu_load  = 1'b0;
         fin.lsu_store = 1'b0;
         fin.branch    = 1'b0;
         fin.jump      = 1'b0;
         fin.md_en     = 1'b0;
      end
      if (raw.rd == 5'd0) begin
         fin.rd_we = 1'b0;
      end
   end

   assign dec_o = fin;

endmodule

// File: rtl/panda_decoder_stage.sv
// Registered decode stage: decodes {instr, pc} into a main register M backed by
// a skid register S, so instr_ready_o is a flop with no path from dec_ready_i.
module panda_decoder_stage
   import panda_pkg::*;
#(
   parameter bit RV32E     = 1'b0,
   parameter bit RV32M     = 1'b0,
   parameter bit SYSTEM_EN = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             instr_valid_i,
   output logic             instr_ready_o,
   input  logic [31:0]      instr_i,
   input  logic [31:0]      pc_i,
   output logic             dec_valid_o,
   input  logic             dec_ready_i,
   output logic [DEC_W-1:0] dec_o
);

   logic [DEC_W-1:0] decoded;
   logic             in_fire, out_fire, m_free;

   logic             m_valid_reg, m_valid_next;
   logic [DEC_W-1:0] m_data_reg, m_data_next;
   logic             s_valid_reg, s_valid_next;
   logic [DEC_W-1:0] s_data_reg, s_data_next;
   logic             ready_reg, ready_next;

   panda_decoder_core #(
      .RV32E     (RV32E),
      .RV32M     (RV32M),
      .SYSTEM_EN (SYSTEM_EN)
   ) u_core (
      .instr_i (instr_i),
      .pc_i    (pc_i),
      .dec_o   (decoded)
   );

   assign in_fire  = instr_valid_i & ready_reg;
   assign out_fire = m_valid_reg & dec_ready_i;
   assign m_free   = !m_valid_reg | out_fire;

   always_comb begin
      m_valid_next = m_valid_reg;
      m_data_next  = m_data_reg;
      s_valid_next = s_valid_reg;
      s_data_next  = s_data_reg;

      if (flush_i) begin
         m_valid_next = 1'b0;
         s_valid_next = 1'b0;
      end else if (m_free) begin
         // ready is low while S is full, so S and a new input never collide.
         if (s_valid_reg) begin
            m_valid_next = 1'b1;
            m_data_next  = s_data_reg;
            s_valid_next = 1'b0;
         end else if (in_fire) begin
            m_valid_next = 1'b1;
            m_data_next  = decoded;
         end else begin
            m_valid_next = 1'b0;
         end
      end else if (in_fire) begin
         s_valid_next = 1'b1;
         s_data_next  = decoded;
      end

      ready_next = !s_valid_next;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m_valid_reg <= 1'b0;
         m_data_reg  <= '0;
         s_valid_reg <= 1'b0;
         s_data_reg  <= '0;
         ready_reg   <= 1'b1;
      end else begin
         m_valid_reg <= m_valid_next;
         m_data_reg  <= m_data_next;
         s_valid_reg <= s_valid_next;
         s_data_reg  <= s_data_next;
         ready_reg   <= ready_next;
      end
   end

   assign instr_ready_o = ready_reg;
   assign dec_valid_o   = m_valid_reg;
   assign dec_o         = m_data_reg;

endmodule

// File: tb/tb_panda_decoder_stage.sv
// Bench for panda_decoder_stage: two parameterisations share one stimulus
// stream and are compared with a 2-deep FIFO model plus a rule-based decoder.
module tb_panda_decoder_stage;
   import panda_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic [31:0]      instr = 32'h0;
   logic [31:0]      pc = 32'h0;
   logic             dec_ready = 1'b0;
   logic             ready_a, valid_a, ready_b, valid_b;
   logic [DEC_W-1:0] dec_a, dec_b;
   decoded_instr_t   da, db;

   int chk_cnt = 0;
   int pass_cnt = 0;

   assign da = dec_a;
   assign db = dec_b;

   always #5 clk = ~clk;

   // dut_a: RV32I + M; dut_b: RV32E without M.
   panda_decoder_stage #(.RV32E(1'b0), .RV32M(1'b1), .SYSTEM_EN(1'b1)) dut_a (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_valid_i(in_valid),
      .instr_ready_o(ready_a), .instr_i(instr), .pc_i(pc), .dec_valid_o(valid_a),
      .dec_ready_i(dec_ready), .dec_o(dec_a));

   panda_decoder_stage #(.RV32E(1'b1), .RV32M(1'b0), .SYSTEM_EN(1'b1)) dut_b (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_valid_i(in_valid),
      .instr_ready_o(ready_b), .instr_i(instr), .pc_i(pc), .dec_valid_o(valid_b),
      .dec_ready_i(dec_ready), .dec_o(dec_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected packet derived from the ISA rules, filling the fields the bench compares.
   function automatic decoded_instr_t ref_decode(input logic [31:0] ins, input logic [31:0] ipc,
                                                 input bit e, input bit m);
      decoded_instr_t r;
      bit ok, wr, u1, u2, ud;
      logic [2:0] f3;
      logic [6:0] f7;
      r = '0;
      r.pc = ipc;
      r.rd = ins[11:7];
      f3 = ins[14:12];
      f7 = ins[31:25];
      ok = 0; wr = 0; u1 = 0; u2 = 0; ud = 0;
      case (ins[6:0])
         7'h37, 7'h17: begin ok = 1; wr = 1; ud = 1; r.imm = {ins[31:12], 12'h000}; end
         7'h6f: begin
            ok = 1; wr = 1; ud = 1; r.jump = 1;
            r.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         end
         7'h67: begin ok = (f3 == 0); wr = 1; ud = 1; u1 = 1; r.jump = 1; r.imm = 32'($signed(ins[31:20])); end
         7'h63: begin
            ok = !(f3 inside {3'd2, 3'd3}); u1 = 1; u2 = 1; r.branch = 1;
            r.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         end
         7'h03: begin
            ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); wr = 1; ud = 1; u1 = 1; r.lsu_load = 1;
            r.imm = 32'($signed(ins[31:20]));
         end
         7'h23: begin
            ok = (f3 < 3); u1 = 1; u2 = 1; r.lsu_store = 1;
            r.imm = 32'($signed({ins[31:25], ins[11:7]}));
         end
         7'h13: begin
            ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
            wr = 1; ud = 1; u1 = 1; r.imm = 32'($signed(ins[31:20]));
         end
         7'h33: begin
            ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (m && f7 == 7'h01);
            wr = 1; ud = 1; u1 = 1; u2 = 1;
            r.md_en = m && (f7 == 7'h01);
            r.md_operator = md_operator_e'(f3);
         end
         7'h0f: begin ok = (f3 == 0); r.fence = ok; end
         7'h73: begin
            r.ecall = (ins == 32'h0000_0073);
            r.ebreak = (ins == 32'h0010_0073);
            ok = r.ecall || r.ebreak;
         end
         default: ok = 0;
      endcase
      if (ins[1:0] != 2'b11) ok = 0;
      if (e && ((u1 && ins[19]) || (u2 && ins[24]) || (ud && ins[11]))) ok = 0;
      r.illegal = !ok;
      r.rd_we = ok && wr && (ins[11:7] != 0);
      if (!ok) begin
         r.lsu_load = 0; r.lsu_store = 0; r.branch = 0; r.jump = 0; r.md_en = 0;
      end
      return r;
   endfunction

   function automatic logic [81:0] key(input decoded_instr_t d);
      logic [2:0] mo;
      mo = d.md_en ? 3'(d.md_operator) : 3'd0;
      return {d.illegal, d.rd_we, d.md_en, mo, d.lsu_load, d.lsu_store, d.branch, d.jump,
              d.fence, d.ecall, d.ebreak, d.imm, d.pc, d.rd};
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] ins;
      ins = $urandom;
      case ($urandom_range(0, 11))
         0: ins[6:0] = 7'h03;  1: ins[6:0] = 7'h0f;  2: ins[6:0] = 7'h13;
         3: ins[6:0] = 7'h17;  4: ins[6:0] = 7'h23;  5: ins[6:0] = 7'h33;
         6: ins[6:0] = 7'h37;  7: ins[6:0] = 7'h63;  8: ins[6:0] = 7'h67;
         9: ins[6:0] = 7'h6f; 10: ins[6:0] = 7'h73;
         default: ;
      endcase
      if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
         case ($urandom_range(0, 3))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            2: ins[31:25] = 7'h01;
            default: ;
         endcase
      end
      if (ins[6:0] == 7'h73) begin
         case ($urandom_range(0, 2))
            0: ins = 32'h0000_0073;
            1: ins = 32'h0010_0073;
            default: ;
         endcase
      end
      if ($urandom_range(0, 15) == 0) ins[1:0] = 2'($urandom_range(0, 2));
      return ins;
   endfunction

   task automatic test_reset();
      rst = 1; in_valid = 1; instr = 32'h0020_81b3; dec_ready = 0;
      tick(); tick();
      rst = 0; in_valid = 0;
      chk_cnt++; if (valid_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_a); else pass_cnt++;
      chk_cnt++; if (dec_a !== '0) $display("FAIL reset_dec: got %h want 0", dec_a); else pass_cnt++;
      chk_cnt++; if (ready_a !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_a); else pass_cnt++;
      chk_cnt++; if (ready_b !== 1'b1) $display("FAIL reset_ready_b: got %b want 1", ready_b); else pass_cnt++;
      $display("test_reset done");
   endtask

   task automatic test_add();
      in_valid = 1; instr = 32'h0020_81b3; pc = 32'h100; dec_ready = 1;
      tick();
      in_valid = 0;
      chk_cnt++; if (valid_a !== 1'b1) $display("FAIL add_valid: got %b want 1", valid_a); else pass_cnt++;
      chk_cnt++; if (da.rd !== 5'd3) $display("FAIL add_rd: got %0d want 3", da.rd); else pass_cnt++;
      chk_cnt++; if (da.rd_we !== 1'b1) $display("FAIL add_rd_we: got %b want 1", da.rd_we); else pass_cnt++;
      chk_cnt++; if (da.alu_operator !== ALU_ADD) $display("FAIL add_alu: got %0d want %0d", da.alu_operator, ALU_ADD); else pass_cnt++;
      chk_cnt++; if (da.illegal !== 1'b0) $display("FAIL add_illegal: got %b want 0", da.illegal); else pass_cnt++;
      chk_cnt++; if (da.pc !== 32'h100) $display("FAIL add_pc: got %h want 100", da.pc); else pass_cnt++;
      tick();
      chk_cnt++; if (valid_a !== 1'b0) $display("FAIL add_drain: got %b want 0", valid_a); else pass_cnt++;
      $display("test_add done");
   endtask

   task automatic test_back_to_back();
      dec_ready = 0; in_valid = 1; instr = 32'h0010_0093; pc = 32'h200;
      tick();
      chk_cnt++; if (ready_a !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", ready_a); else pass_cnt++;
      instr = 32'h0020_0113; pc = 32'h204;
      tick();
      chk_cnt++; if (ready_a !== 1'b0) $display("FAIL b2b_ready2: got %b want 0", ready_a); else pass_cnt++;
      instr = 32'h0030_0193; pc = 32'h208;
      tick();
      chk_cnt++; if (ready_a !== 1'b0) $display("FAIL b2b_hold_ready: got %b want 0", ready_a); else pass_cnt++;
      chk_cnt++; if (valid_a !== 1'b1 || da.pc !== 32'h200) $display("FAIL b2b_first: got v=%b pc=%h want v=1 pc=200", valid_a, da.pc); else pass_cnt++;
      dec_ready = 1;
      tick();
      chk_cnt++; if (valid_a !== 1'b1 || da.pc !== 32'h204 || da.imm !== 32'd2) $display("FAIL b2b_second: got v=%b pc=%h imm=%h want v=1 pc=204 imm=2", valid_a, da.pc, da.imm); else pass_cnt++;
      chk_cnt++; if (ready_a !== 1'b1) $display("FAIL b2b_ready3: got %b want 1", ready_a); else pass_cnt++;
      tick();
      in_valid = 0;
      chk_cnt++; if (valid_a !== 1'b1 || da.pc !== 32'h208 || da.imm !== 32'd3) $display("FAIL b2b_third: got v=%b pc=%h imm=%h want v=1 pc=208 imm=3", valid_a, da.pc, da.imm); else pass_cnt++;
      tick();
      chk_cnt++; if (valid_a !== 1'b0) $display("FAIL b2b_empty: got %b want 0", valid_a); else pass_cnt++;
      $display("test_back_to_back done");
   endtask

   task automatic test_flush();
      dec_ready = 0; in_valid = 1; instr = 32'h0010_0093; pc = 32'h300;
      tick();
      instr = 32'h0020_0113; pc = 32'h304;
      tick();
      flush = 1; instr = 32'h0030_0193; pc = 32'h308;
      tick();
      flush = 0; in_valid = 0; dec_ready = 1;
      chk_cnt++; if (valid_a !== 1'b0) $display("FAIL flush_valid: got %b want 0", valid_a); else pass_cnt++;
      chk_cnt++; if (ready_a !== 1'b1) $display("FAIL flush_ready: got %b want 1", ready_a); else pass_cnt++;
      tick();
      chk_cnt++; if (valid_a !== 1'b0) $display("FAIL flush_ghost: got %b pc=%h want 0", valid_a, da.pc); else pass_cnt++;
      dec_ready = 0; in_valid = 1; instr = 32'h0010_0093; pc = 32'h400;
      tick();
      instr = 32'h0020_0113; pc = 32'h404;
      tick();
      rst = 1; in_valid = 0;
      tick();
      rst = 0; dec_ready = 1;
      chk_cnt++; if (valid_a !== 1'b0 || ready_a !== 1'b1) $display("FAIL reset_mid: got v=%b r=%b want v=0 r=1", valid_a, ready_a); else pass_cnt++;
      tick();
      chk_cnt++; if (valid_a !== 1'b0) $display("FAIL reset_mid_ghost: got %b want 0", valid_a); else pass_cnt++;
      $display("test_flush done");
   endtask

   task automatic send_one(input logic [31:0] ins, input logic [31:0] ipc);
      in_valid = 1; instr = ins; pc = ipc; dec_ready = 1;
      tick();
      in_valid = 0;
   endtask

   task automatic test_decode_params();
      send_one(32'h0273_02b3, 32'h500);
      chk_cnt++; if (db.illegal !== 1'b1 || db.rd_we !== 1'b0) $display("FAIL mul_nom: got ill=%b we=%b want ill=1 we=0", db.illegal, db.rd_we); else pass_cnt++;
      chk_cnt++; if (da.md_en !== 1'b1 || da.md_operator !== MD_MUL || da.rd_we !== 1'b1 || da.rd_data_sel !== RD_DATA_MD)
         $display("FAIL mul_m: got md=%b op=%0d we=%b sel=%0d want md=1 op=0 we=1 sel=3", da.md_en, da.md_operator, da.rd_we, da.rd_data_sel); else pass_cnt++;
      send_one(32'h0010_0813, 32'h504);
      chk_cnt++; if (db.illegal !== 1'b1) $display("FAIL addi_x16_e: got ill=%b want 1", db.illegal); else pass_cnt++;
      chk_cnt++; if (da.illegal !== 1'b0 || da.imm !== 32'd1 || da.rd_we !== 1'b1) $display("FAIL addi_x16_i: got ill=%b imm=%h we=%b want ill=0 imm=1 we=1", da.illegal, da.imm, da.rd_we); else pass_cnt++;
      send_one(32'h0000_0073, 32'h508);
      chk_cnt++; if (da.ecall !== 1'b1 || da.illegal !== 1'b0 || da.rd_we !== 1'b0) $display("FAIL ecall: got ec=%b ill=%b we=%b want ec=1 ill=0 we=0", da.ecall, da.illegal, da.rd_we); else pass_cnt++;
      send_one(32'h0020_0073, 32'h50c);
      chk_cnt++; if (da.illegal !== 1'b1 || da.pc !== 32'h50c) $display("FAIL sys_bad: got ill=%b pc=%h want ill=1 pc=50c", da.illegal, da.pc); else pass_cnt++;
      send_one(32'hffff_ffff, 32'h510);
      chk_cnt++; if (da.illegal !== 1'b1 || da.rd_we !== 1'b0) $display("FAIL all_ones: got ill=%b we=%b want ill=1 we=0", da.illegal, da.rd_we); else pass_cnt++;
      send_one(32'h1234_5037, 32'h514);
      chk_cnt++; if (da.rd_we !== 1'b0 || da.illegal !== 1'b0 || da.imm !== 32'h1234_5000) $display("FAIL lui_x0: got we=%b ill=%b imm=%h want we=0 ill=0 imm=12345000", da.rd_we, da.illegal, da.imm); else pass_cnt++;
      tick();
      $display("test_decode_params done");
   endtask

   task automatic test_random();
      decoded_instr_t qa[$];
      decoded_instr_t qb[$];
      bit in_fire, out_fire;
      int errs_before;
      errs_before = chk_cnt - pass_cnt;
      for (int i = 0; i < 800; i++) begin
         chk_cnt++; if (ready_a !== (qa.size() < 2)) $display("FAIL rnd_ready_a cyc %0d: got %b want %b", i, ready_a, qa.size() < 2); else pass_cnt++;
         chk_cnt++; if (valid_a !== (qa.size() > 0)) $display("FAIL rnd_valid_a cyc %0d: got %b want %b", i, valid_a, qa.size() > 0); else pass_cnt++;
         chk_cnt++; if (valid_b !== (qb.size() > 0)) $display("FAIL rnd_valid_b cyc %0d: got %b want %b", i, valid_b, qb.size() > 0); else pass_cnt++;
         if (qa.size() > 0) begin
            chk_cnt++; if (key(da) !== key(qa[0])) $display("FAIL rnd_pkt_a cyc %0d: got %h want %h", i, key(da), key(qa[0])); else pass_cnt++;
            chk_cnt++; if (key(db) !== key(qb[0])) $display("FAIL rnd_pkt_b cyc %0d: got %h want %h", i, key(db), key(qb[0])); else pass_cnt++;
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         dec_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         instr     = gen_instr();
         pc        = $urandom & 32'hffff_fffc;
         in_fire   = in_valid && (qa.size() < 2);
         out_fire  = dec_ready && (qa.size() > 0);
         tick();
         if (flush) begin
            qa.delete();
            qb.delete();
         end else begin
            if (out_fire) begin
               void'(qa.pop_front());
               void'(qb.pop_front());
            end
            if (in_fire) begin
               qa.push_back(ref_decode(instr, pc, 1'b0, 1'b1));
               qb.push_back(ref_decode(instr, pc, 1'b1, 1'b0));
            end
         end
      end
      in_valid = 0; flush = 0;
      $display("test_random done: %0d new failures", chk_cnt - pass_cnt - errs_before);
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_flush();
      test_decode_params();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
